// File: rtl/axi_lite_multi_channel_stream_bridge_if.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_multi_channel_stream_bridge_if
// Brief  : AXI4-Lite bus (32-bit data) with master/slave modports.
// Rev    : 1.0  initial release
// ============================================================================
interface axi_lite_multi_channel_stream_bridge_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]            AWPROT;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [31:0]           RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_multi_channel_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_multi_channel_stream_bridge
// Brief  : AXI4-Lite slave feeding per-channel TX FIFOs and draining RX FIFOs.
//          Optional macro CHANNEL_COUNTERS_EN adds per-channel handshake counters.
// Rev    : 1.0  initial release
// ============================================================================
module axi_lite_multi_channel_stream_bridge #(
  parameter int NUM_CHANNELS = 4,
  parameter int WORD_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESETN,
  axi_lite_multi_channel_stream_bridge_if.slave s_axi,
  output logic [NUM_CHANNELS*WORD_WIDTH-1:0] tx_data,
  output logic [NUM_CHANNELS-1:0]            tx_valid,
  input  logic [NUM_CHANNELS-1:0]            tx_ready,
  input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] rx_data,
  input  logic [NUM_CHANNELS-1:0]            rx_valid,
  output logic [NUM_CHANNELS-1:0]            rx_ready,
  output logic                               array_enable,
  input  logic                               array_halted
);
  localparam int         AW          = $clog2(FIFO_DEPTH);
  localparam int         PW          = AW + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        enable_q, flush_q, live_q;

  logic [WORD_WIDTH-1:0] tx_mem_q [NUM_CHANNELS][FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] rx_mem_q [NUM_CHANNELS][FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q [NUM_CHANNELS];
  logic [PW-1:0] tx_rd_q [NUM_CHANNELS];
  logic [PW-1:0] rx_wr_q [NUM_CHANNELS];
  logic [PW-1:0] rx_rd_q [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic [NUM_CHANNELS-1:0] w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [NUM_CHANNELS-1:0] w_wr_sel, w_rd_sel;
  logic [5:0]  w_wr_idx, w_rd_idx;
  logic        w_wr_ch_ok, w_rd_ch_ok, w_wr_en, w_rd_en, w_ctrl_wr;
  logic [1:0]  w_wr_resp, w_rd_resp;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_wr_idx   = s_axi.AWADDR[7:2];
  assign w_rd_idx   = s_axi.ARADDR[7:2];
  assign w_wr_ch_ok = int'(w_wr_idx[3:0]) < NUM_CHANNELS;
  assign w_rd_ch_ok = int'(w_rd_idx[3:0]) < NUM_CHANNELS;
  assign w_ctrl_wr  = w_wr_en && (w_wr_idx == 6'd0) && s_axi.WSTRB[0];
  assign w_unused   = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.WDATA, s_axi.WSTRB,
                        s_axi.AWADDR, s_axi.ARADDR};

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      assign w_wr_sel[c]   = (w_wr_idx[3:0] == 4'(c));
      assign w_rd_sel[c]   = (w_rd_idx[3:0] == 4'(c));
      assign w_tx_empty[c] = (tx_wr_q[c] == tx_rd_q[c]);
      assign w_tx_full[c]  = ((tx_wr_q[c] - tx_rd_q[c]) == PW'(FIFO_DEPTH));
      assign w_rx_empty[c] = (rx_wr_q[c] == rx_rd_q[c]);
      assign w_rx_full[c]  = ((rx_wr_q[c] - rx_rd_q[c]) == PW'(FIFO_DEPTH));
      assign tx_data[c*WORD_WIDTH +: WORD_WIDTH] = tx_mem_q[c][tx_rd_q[c][AW-1:0]];
      assign tx_valid[c]   = !w_tx_empty[c];
      // Keep the array from pushing until reset has been released.
      assign rx_ready[c]   = !w_rx_full[c] && live_q;
      assign w_tx_pop[c]   = tx_valid[c] && tx_ready[c];
      assign w_rx_push[c]  = rx_valid[c] && rx_ready[c];
      assign w_tx_push[c]  = w_wr_en && (w_wr_idx[5:4] == 2'b01) && w_wr_ch_ok
                             && w_wr_sel[c] && !w_tx_full[c];
      assign w_rx_pop[c]   = w_rd_en && (w_rd_idx[5:4] == 2'b10) && w_rd_ch_ok
                             && w_rd_sel[c] && !w_rx_empty[c];
    end
  endgenerate

  always_ff @(posedge S_AXI_ACLK) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_tx_push[c]) tx_mem_q[c][tx_wr_q[c][AW-1:0]] <= s_axi.WDATA[WORD_WIDTH-1:0];
      if (w_rx_push[c]) rx_mem_q[c][rx_wr_q[c][AW-1:0]] <= rx_data[c*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // Flush wins over any push or pop landing in the same cycle.
  always_ff @(posedge S_AXI_ACLK) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!S_AXI_ARESETN || flush_q) begin
        tx_wr_q[c] <= '0;
        tx_rd_q[c] <= '0;
        rx_wr_q[c] <= '0;
        rx_rd_q[c] <= '0;
      end else begin
        if (w_tx_push[c]) tx_wr_q[c] <= tx_wr_q[c] + PW'(1);
        if (w_tx_pop[c])  tx_rd_q[c] <= tx_rd_q[c] + PW'(1);
        if (w_rx_push[c]) rx_wr_q[c] <= rx_wr_q[c] + PW'(1);
        if (w_rx_pop[c])  rx_rd_q[c] <= rx_rd_q[c] + PW'(1);
      end
    end
  end

`ifdef CHANNEL_COUNTERS_EN
  logic [31:0] tx_cnt_q [NUM_CHANNELS];
  logic [31:0] rx_cnt_q [NUM_CHANNELS];

  always_ff @(posedge S_AXI_ACLK) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!S_AXI_ARESETN || flush_q) begin
        tx_cnt_q[c] <= '0;
        rx_cnt_q[c] <= '0;
      end else begin
        if (w_tx_pop[c])  tx_cnt_q[c] <= tx_cnt_q[c] + 32'd1;
        if (w_rx_push[c]) rx_cnt_q[c] <= rx_cnt_q[c] + 32'd1;
      end
    end
  end
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      enable_q <= 1'b0;
      flush_q  <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      flush_q <= 1'b0;
      if (w_ctrl_wr) begin
        enable_q <= s_axi.WDATA[0];
        flush_q  <= s_axi.WDATA[1];
      end
    end
  end
  assign array_enable = enable_q;

  always_comb begin
    w_wr_resp = RESP_DECERR;
    case (w_wr_idx[5:4])
      2'b00:   if (w_wr_idx[3:2] == 2'b00) w_wr_resp = RESP_OKAY;
      2'b01:   if (w_wr_ch_ok) w_wr_resp = |(w_tx_full & w_wr_sel) ? RESP_SLVERR : RESP_OKAY;
      2'b10:   if (w_wr_ch_ok) w_wr_resp = RESP_OKAY;
      default: begin
`ifdef CHANNEL_COUNTERS_EN
        if (int'(w_wr_idx[2:0]) < NUM_CHANNELS) w_wr_resp = RESP_OKAY;
`endif
      end
    endcase
  end

  always_comb begin
    w_rd_resp = RESP_DECERR;
    w_rd_data = '0;
    case (w_rd_idx[5:4])
      2'b00: begin
        w_rd_resp = RESP_OKAY;
        case (w_rd_idx[3:0])
          4'd0:    w_rd_data[0] = enable_q;
          4'd1:    w_rd_data[2:0] = {|(~w_rx_empty), |tx_valid, array_halted};
          4'd2:    w_rd_data[NUM_CHANNELS-1:0] = w_tx_full;
          4'd3:    w_rd_data[NUM_CHANNELS-1:0] = w_rx_empty;
          default: w_rd_resp = RESP_DECERR;
        endcase
      end
      2'b01: if (w_rd_ch_ok) w_rd_resp = RESP_OKAY;
      2'b10: begin
        if (w_rd_ch_ok) begin
          w_rd_resp = |(w_rx_empty & w_rd_sel) ? RESP_SLVERR : RESP_OKAY;
          for (int c = 0; c < NUM_CHANNELS; c++)
            if (w_rd_sel[c] && !w_rx_empty[c])
              w_rd_data[WORD_WIDTH-1:0] = rx_mem_q[c][rx_rd_q[c][AW-1:0]];
        end
      end
      default: begin
`ifdef CHANNEL_COUNTERS_EN
        for (int c = 0; c < NUM_CHANNELS && c < 8; c++) begin
          if (w_rd_idx[2:0] == 3'(c)) begin
            w_rd_resp = RESP_OKAY;
            w_rd_data = w_rd_idx[3] ? rx_cnt_q[c] : tx_cnt_q[c];
          end
        end
`endif
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wstate_q <= W_IDLE;
      bresp_q  <= 2'b00;
      rstate_q <= R_IDLE;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      bresp_q  <= bresp_d;
      rstate_q <= rstate_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  // Address and data are only taken together, one cycle after both are seen.
  always_comb begin
    wstate_d      = wstate_q;
    bresp_d       = bresp_q;
    w_wr_en       = 1'b0;
    s_axi.AWREADY = 1'b0;
    s_axi.WREADY  = 1'b0;
    s_axi.BVALID  = 1'b0;
    case (wstate_q)
      W_IDLE:   if (s_axi.AWVALID && s_axi.WVALID) wstate_d = W_ACCEPT;
      W_ACCEPT: begin
        s_axi.AWREADY = 1'b1;
        s_axi.WREADY  = 1'b1;
        w_wr_en       = 1'b1;
        bresp_d       = w_wr_resp;
        wstate_d      = W_RESP;
      end
      W_RESP: begin
        s_axi.BVALID = 1'b1;
        if (s_axi.BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end
  assign s_axi.BRESP = bresp_q;

  always_comb begin
    rstate_d      = rstate_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    w_rd_en       = 1'b0;
    s_axi.ARREADY = 1'b0;
    s_axi.RVALID  = 1'b0;
    case (rstate_q)
      R_IDLE:   if (s_axi.ARVALID) rstate_d = R_ACCEPT;
      R_ACCEPT: begin
        s_axi.ARREADY = 1'b1;
        w_rd_en       = 1'b1;
        rresp_d       = w_rd_resp;
        rdata_d       = w_rd_data;
        rstate_d      = R_DATA;
      end
      R_DATA: begin
        s_axi.RVALID = 1'b1;
        if (s_axi.RREADY) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end
  assign s_axi.RRESP = rresp_q;
  assign s_axi.RDATA = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_multi_channel_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_lite_multi_channel_stream_bridge
// Brief  : Scoreboard bench for the AXI-Lite multi-channel stream bridge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_lite_multi_channel_stream_bridge;
  localparam int NCH = 4;
  localparam int WW  = 32;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_multi_channel_stream_bridge_if #(.ADDR_WIDTH(8)) axi ();
  logic [NCH*WW-1:0] tx_data, rx_data;
  logic [NCH-1:0]    tx_valid, tx_ready, rx_valid, rx_ready;
  logic              array_enable, array_halted;

  axi_lite_multi_channel_stream_bridge #(
    .NUM_CHANNELS(NCH), .WORD_WIDTH(WW), .FIFO_DEPTH(8), .ADDR_WIDTH(8)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rstn),
    .s_axi        (axi),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .array_enable (array_enable),
    .array_halted (array_halted)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_tx [NCH][$];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lead > 0 presents AW alone for that many cycles before W joins it.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input int lead);
    int n;
    logic seen;
    exp_b.push_back(resp);
    axi.AWADDR = addr; axi.AWVALID = 1'b1;
    axi.WDATA = data;  axi.WSTRB = strb;
    if (lead > 0) begin
      seen = 1'b0;
      for (int i = 0; i < lead; i++) begin
        @(negedge clk);
        seen = seen | axi.AWREADY | axi.WREADY;
      end
      check("aw_alone_not_accepted", seen, 1'b0);
      tick();
    end
    axi.WVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.AWREADY && n < 20);
    check("awready", axi.AWREADY, 1'b1);
    check("wready_with_aw", axi.WREADY, 1'b1);
    tick();
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.BVALID && n < 20);
    check("bvalid", axi.BVALID, 1'b1);
    check($sformatf("bresp_%02h", addr), axi.BRESP, exp_b.pop_front());
    tick();
    axi.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp);
    int n;
    logic [33:0] e;
    exp_r.push_back({resp, data});
    axi.ARADDR = addr; axi.ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.ARREADY && n < 20);
    check("arready", axi.ARREADY, 1'b1);
    tick();
    axi.ARVALID = 1'b0; axi.RREADY = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.RVALID && n < 20);
    e = exp_r.pop_front();
    check($sformatf("rresp_%02h", addr), {axi.RVALID, axi.RRESP}, {1'b1, e[33:32]});
    check($sformatf("rdata_%02h", addr), axi.RDATA, e[31:0]);
    tick();
    axi.RREADY = 1'b0;
  endtask

  task automatic rx_push(input int c, input logic [31:0] data);
    int n;
    rx_data[c*WW +: WW] = data;
    rx_valid[c] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rx_ready[c] && n < 20);
    check("rx_ready", rx_ready[c], 1'b1);
    tick();
    rx_valid[c] = 1'b0;
  endtask

  // Stream-side scoreboard: every TX handshake must match the oldest pushed word.
  always @(negedge clk) begin
    if (rstn) begin
      for (int c = 0; c < NCH; c++) begin
        if (tx_valid[c] && tx_ready[c]) begin
          if (exp_tx[c].size() == 0) check($sformatf("tx_extra_ch%0d", c), tx_valid[c], 1'b0);
          else check($sformatf("tx_data_ch%0d", c), tx_data[c*WW +: WW], exp_tx[c].pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    axi.AWADDR = '0; axi.AWPROT = '0; axi.AWVALID = 1'b0;
    axi.WDATA = '0;  axi.WSTRB = '0;  axi.WVALID = 1'b0; axi.BREADY = 1'b0;
    axi.ARADDR = '0; axi.ARPROT = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b0;
    tx_ready = '0; rx_valid = '0; rx_data = '0; array_halted = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_handshakes", {axi.AWREADY, axi.WREADY, axi.BVALID, axi.ARREADY, axi.RVALID}, 5'b0);
    check("rst_resp_data", {axi.BRESP, axi.RRESP, axi.RDATA}, 36'b0);
    check("rst_streams", {tx_valid, rx_ready, array_enable}, 9'b0);
    tick();
    rstn = 1'b1;
    tick();
    axi_read(8'h0C, 32'hF, OKAY);
    axi_read(8'h08, 32'h0, OKAY);
    axi_read(8'h00, 32'h0, OKAY);

    tx_ready[1] = 1'b1;
    exp_tx[1].push_back(32'h11); axi_write(8'h44, 32'h11, 4'hF, OKAY, 0);
    exp_tx[1].push_back(32'h22); axi_write(8'h44, 32'h22, 4'hF, OKAY, 0);
    repeat (3) tick();
    check("ch1_drained", exp_tx[1].size(), 0);
    tx_ready = '0;

    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_tx[0].push_back(32'h100 + i);
      axi_write(8'h40, 32'h100 + i, 4'hF, (i < 8) ? OKAY : SLVERR, 0);
    end
    axi_read(8'h08, 32'h1, OKAY);
    axi_read(8'h04, 32'h2, OKAY);
    array_halted = 1'b1;
    axi_read(8'h04, 32'h3, OKAY);
    array_halted = 1'b0;
    tx_ready[0] = 1'b1;
    n = 0;
    while (exp_tx[0].size() != 0 && n < 40) begin tick(); n++; end
    tick();
    check("ch0_drained", {tx_valid[0], 32'(exp_tx[0].size())}, 33'd0);
    tx_ready = '0;
`ifdef CHANNEL_COUNTERS_EN
    axi_read(8'hC0, 32'd8, OKAY);
    axi_read(8'hC4, 32'd2, OKAY);
`else
    axi_read(8'hC0, 32'd0, DECERR);
`endif

    rx_push(2, 32'hABCD);
    axi_read(8'h0C, 32'hB, OKAY);
`ifdef CHANNEL_COUNTERS_EN
    axi_read(8'hE8, 32'd1, OKAY);
`endif
    axi_read(8'h88, 32'hABCD, OKAY);
    axi_read(8'h88, 32'h0, SLVERR);
    axi_read(8'h0C, 32'hF, OKAY);

    axi_read(8'h50, 32'h0, DECERR);
    axi_read(8'h10, 32'h0, DECERR);
    axi_write(8'h50, 32'h5, 4'hF, DECERR, 0);
    axi_read(8'h04, 32'h0, OKAY);

    axi_write(8'h00, 32'h1, 4'hF, OKAY, 5);
    @(negedge clk);
    check("enable_set", array_enable, 1'b1);
    tick();

    exp_tx[0].push_back(32'hAA); axi_write(8'h40, 32'hAA, 4'hF, OKAY, 0);
    exp_tx[2].push_back(32'hBB); axi_write(8'h48, 32'hBB, 4'hF, OKAY, 0);
    rx_push(1, 32'h55);
    axi_read(8'h04, 32'h6, OKAY);
    axi_write(8'h00, 32'h3, 4'hF, OKAY, 0);
    for (int c = 0; c < NCH; c++) exp_tx[c].delete();
    @(negedge clk);
    check("flush_tx_valid", tx_valid, 4'b0);
    check("flush_enable", array_enable, 1'b1);
    tick();
    axi_read(8'h0C, 32'hF, OKAY);
    axi_read(8'h08, 32'h0, OKAY);
    axi_read(8'h04, 32'h0, OKAY);
    axi_read(8'h00, 32'h1, OKAY);
`ifdef CHANNEL_COUNTERS_EN
    axi_read(8'hC0, 32'd0, OKAY);
`endif

    axi_write(8'h00, 32'h0, 4'b1110, OKAY, 0);
    axi_read(8'h00, 32'h1, OKAY);
    axi_write(8'h00, 32'h0, 4'b0001, OKAY, 0);
    axi_read(8'h00, 32'h0, OKAY);
    @(negedge clk);
    check("enable_cleared", array_enable, 1'b0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
